// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and
// sizing of the shared cycle counter.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Width holding 0 .. max(cycle limits)-1; never narrower than one bit.
  function automatic int unsigned cycle_cnt_width(input int unsigned reset_cycles,
                                                  input int unsigned stable_cycles,
                                                  input int unsigned timeout_cycles);
    int unsigned max_c;
    max_c = reset_cycles;
    if (stable_cycles > max_c) max_c = stable_cycles;
    if (timeout_cycles > max_c) max_c = timeout_cycles;
    return (max_c > 1) ? $clog2(max_c) : 1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit, asynchronously
// cleared to 0. Also used by downstream clock domains to re-synchronize
// sys_reset_n deassertion.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; the last stage is the synchronized output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Controller side of the SB_PLL40: drives RESETB, qualifies LOCK, releases
// the system reset once lock has been stable, retries the PLL on lock
// timeout and keeps saturating debug counts of timeouts and lock losses.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned PLL_RESET_CYCLES = 12,
  parameter int unsigned STABLE_CYCLES    = 1200,
  parameter int unsigned TIMEOUT_CYCLES   = 12000,
  parameter int unsigned CNT_W            = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             soft_reset,
  output logic             pll_resetb,
  output logic             sys_reset_n,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [1:0]       state
);

  localparam int unsigned CycW =
      cycle_cnt_width(PLL_RESET_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CycW-1:0]  ResetLast   = CycW'(PLL_RESET_CYCLES - 1);
  localparam logic [CycW-1:0]  StableLast  = CycW'(STABLE_CYCLES - 1);
  localparam logic [CycW-1:0]  TimeoutLast = CycW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax      = '1;

  logic             lock_s;
  seq_state_e       state_q, state_d;
  logic [CycW-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0] lock_loss_q, lock_loss_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic             pll_resetb_q, sys_reset_n_q, ready_q;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  // Next state, shared cycle counter and saturating event counters.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q + 1'b1;
    lock_loss_d = lock_loss_q;
    timeout_d   = timeout_q;

    if (soft_reset) begin
      // Overrides everything, including a coincident lock loss in RUN.
      state_d = PLL_RST;
    end else begin
      unique case (state_q)
        PLL_RST: begin
          if (cyc_q == ResetLast) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABILIZE;
          end else if (cyc_q == TimeoutLast) begin
            state_d = PLL_RST;
            if (timeout_q != CntMax) timeout_d = timeout_q + 1'b1;
          end
        end
        STABILIZE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (cyc_q == StableLast) begin
            state_d = RUN;
          end
        end
        RUN: begin
          cyc_d = cyc_q;  // nothing is timed in RUN
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            if (lock_loss_q != CntMax) lock_loss_d = lock_loss_q + 1'b1;
          end
        end
        default: state_d = PLL_RST;
      endcase
    end

    // Soft reset in PLL_RST does not change state but must restart the count.
    if (soft_reset || (state_d != state_q)) cyc_d = '0;
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they change on the same edge as the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= PLL_RST;
      cyc_q         <= '0;
      lock_loss_q   <= '0;
      timeout_q     <= '0;
      pll_resetb_q  <= 1'b0;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      lock_loss_q   <= lock_loss_d;
      timeout_q     <= timeout_d;
      pll_resetb_q  <= (state_d != PLL_RST);
      sys_reset_n_q <= (state_d == RUN);
      ready_q       <= (state_d == RUN);
    end
  end

  assign pll_resetb      = pll_resetb_q;
  assign sys_reset_n     = sys_reset_n_q;
  assign ready           = ready_q;
  assign lock_loss_count = lock_loss_q;
  assign timeout_count   = timeout_q;
  assign state           = state_q;

endmodule
